// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the write-back commit unit: register index width,
// WB control vector bit positions and the HI/LO update selector.
package wb_commit_unit_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NREG      = 32;
  localparam logic [REG_IDX_W-1:0] LINK_REG = 5'd31;

  localparam int CTL_JAL        = 0;
  localparam int CTL_LOAD_BYTE  = 1;
  localparam int CTL_FP_WRITE   = 2;
  localparam int CTL_HILO_WRITE = 3;
  localparam int CTL_MULDIV     = 4;
  localparam int CTL_FLOAT_WR   = 5;
  localparam int CTL_MEM2REG64  = 6;
  localparam int CTL_MEM2REG    = 7;
  localparam int CTL_REG_WRITE  = 8;
  localparam int CTL_WRITE64    = 9;
  localparam int CTL_W          = 10;

  typedef enum logic [1:0] {
    HILO_NONE,
    HILO_MULDIV,
    HILO_HI,
    HILO_LO
  } hilo_sel_e;

  // A full mul/div result always beats a single-register move.
  function automatic hilo_sel_e hilo_select(input logic muldiv,
                                            input logic hilo_wr,
                                            input logic sel_hi);
    return muldiv  ? HILO_MULDIV :
           hilo_wr ? (sel_hi ? HILO_HI : HILO_LO) :
                     HILO_NONE;
  endfunction

endpackage

// File: rtl/wb_commit_unit_if.sv
// WB-stage fields coming from MEM/WB plus the ID-stage read ports and
// architectural state outputs of the commit unit.
interface wb_commit_unit_if;

  logic [63:0] OUT_ALU64_WB;
  logic [63:0] OUT_data64_WB;
  logic [31:0] Memory_WB;
  logic [31:0] ALU_WB;
  logic [4:0]  RegWr_WB;
  logic [31:0] HILO_write_WB;
  logic        RegWrite;
  logic        MemToReg;
  logic        MemToReg64;
  logic        MulDiv_control;
  logic        HILO_write_control;
  logic        Jal_control;
  logic        FPwrite_control;
  logic        Load_Byte_control;
  logic        float_control_write;
  logic        Write32_64;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic [4:0]  Fs_ID;
  logic [4:0]  Ft_ID;
  logic [31:0] Rs_data;
  logic [31:0] Rt_data;
  logic [31:0] Fs_data;
  logic [31:0] Ft_data;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        FCC_out;
  logic [31:0] Commit_count;

  modport master (
    output OUT_ALU64_WB, OUT_data64_WB, Memory_WB, ALU_WB, RegWr_WB, HILO_write_WB,
           RegWrite, MemToReg, MemToReg64, MulDiv_control, HILO_write_control,
           Jal_control, FPwrite_control, Load_Byte_control, float_control_write,
           Write32_64, Rs_ID, Rt_ID, Fs_ID, Ft_ID,
    input  Rs_data, Rt_data, Fs_data, Ft_data, HI_out, LO_out, FCC_out, Commit_count
  );

  modport slave (
    input  OUT_ALU64_WB, OUT_data64_WB, Memory_WB, ALU_WB, RegWr_WB, HILO_write_WB,
           RegWrite, MemToReg, MemToReg64, MulDiv_control, HILO_write_control,
           Jal_control, FPwrite_control, Load_Byte_control, float_control_write,
           Write32_64, Rs_ID, Rt_ID, Fs_ID, Ft_ID,
    output Rs_data, Rt_data, Fs_data, Ft_data, HI_out, LO_out, FCC_out, Commit_count
  );

endinterface

// File: rtl/wb_commit_unit_regfile_2r2w.sv
// 32x32 register file with two combinational read ports, two write ports and
// write-through bypass; ZERO_R0 hardwires entry 0 to zero.
module regfile_2r2w
  import wb_commit_unit_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 we_a,
  input  logic [REG_IDX_W-1:0] waddr_a,
  input  logic [31:0]          wdata_a,
  input  logic                 we_b,
  input  logic [REG_IDX_W-1:0] waddr_b,
  input  logic [31:0]          wdata_b,
  input  logic [REG_IDX_W-1:0] raddr_0,
  input  logic [REG_IDX_W-1:0] raddr_1,
  output logic [31:0]          rdata_0,
  output logic [31:0]          rdata_1
);

  logic [31:0] mem [NREG];

  // Port b is applied last so it wins on a same-index collision, matching the bypass.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we_a && !(ZERO_R0 && waddr_a == '0)) begin
        mem[waddr_a] <= wdata_a;
      end
      if (we_b && !(ZERO_R0 && waddr_b == '0)) begin
        mem[waddr_b] <= wdata_b;
      end
    end
  end

  function automatic logic [31:0] read_port(input logic [REG_IDX_W-1:0] addr);
    if (ZERO_R0 && addr == '0) begin
      return '0;
    end else if (we_b && waddr_b == addr) begin
      return wdata_b;
    end else if (we_a && waddr_a == addr) begin
      return wdata_a;
    end
    return mem[addr];
  endfunction

  always_comb begin
    rdata_0 = read_port(raddr_0);
    rdata_1 = read_port(raddr_1);
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: selects WB result data and commits it to the integer
// and FP register files, HI/LO and FCC, with bypass to the ID read ports.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
(
  input logic              Clk,
  input logic              Rst,
  wb_commit_unit_if.slave  bus
);

  logic [CTL_W-1:0]     ctl;
  logic [31:0]          data32;
  logic [63:0]          data64;
  logic                 int_we;
  logic [REG_IDX_W-1:0] int_dst;
  logic                 fp_we_lo;
  logic                 fp_we_hi;
  logic [REG_IDX_W-1:0] fp_addr_lo;
  logic [REG_IDX_W-1:0] fp_addr_hi;
  logic [31:0]          fp_data_lo;
  logic                 fcc_we;
  logic                 any_write;
  hilo_sel_e            hilo_sel;
  logic [31:0]          hi_q;
  logic [31:0]          lo_q;
  logic                 fcc_q;
  logic [31:0]          commit_cnt;

  always_comb begin
    ctl                 = '0;
    ctl[CTL_JAL]        = bus.Jal_control;
    ctl[CTL_LOAD_BYTE]  = bus.Load_Byte_control;
    ctl[CTL_FP_WRITE]   = bus.FPwrite_control;
    ctl[CTL_HILO_WRITE] = bus.HILO_write_control;
    ctl[CTL_MULDIV]     = bus.MulDiv_control;
    ctl[CTL_FLOAT_WR]   = bus.float_control_write;
    ctl[CTL_MEM2REG64]  = bus.MemToReg64;
    ctl[CTL_MEM2REG]    = bus.MemToReg;
    ctl[CTL_REG_WRITE]  = bus.RegWrite;
    ctl[CTL_WRITE64]    = bus.Write32_64;
  end

  // Data select and write enables; every enable is masked by reset so the
  // bypass path never exposes a write that will not land.
  always_comb begin
    data32 = bus.ALU_WB;
    if (!ctl[CTL_JAL] && ctl[CTL_MEM2REG]) begin
      data32 = ctl[CTL_LOAD_BYTE] ? {{24{bus.Memory_WB[7]}}, bus.Memory_WB[7:0]}
                                  : bus.Memory_WB;
    end
    data64     = ctl[CTL_MEM2REG64] ? bus.OUT_data64_WB : bus.OUT_ALU64_WB;

    int_we     = !Rst && (ctl[CTL_REG_WRITE] || ctl[CTL_JAL]) && !ctl[CTL_FP_WRITE];
    int_dst    = ctl[CTL_JAL] ? LINK_REG : bus.RegWr_WB;

    fp_we_lo   = !Rst && ctl[CTL_FP_WRITE];
    fp_we_hi   = !Rst && ctl[CTL_FP_WRITE] && ctl[CTL_WRITE64];
    fp_addr_lo = ctl[CTL_WRITE64] ? {bus.RegWr_WB[4:1], 1'b0} : bus.RegWr_WB;
    fp_addr_hi = {bus.RegWr_WB[4:1], 1'b1};
    fp_data_lo = ctl[CTL_WRITE64] ? data64[31:0] : data32;

    hilo_sel   = hilo_select(ctl[CTL_MULDIV], ctl[CTL_HILO_WRITE], bus.RegWr_WB[0]);
    fcc_we     = !Rst && ctl[CTL_FLOAT_WR];
    any_write  = int_we || fp_we_lo || fcc_we || (!Rst && hilo_sel != HILO_NONE);
  end

  regfile_2r2w #(.ZERO_R0(1'b1)) u_int_rf (
    .Clk     (Clk),
    .Rst     (Rst),
    .we_a    (int_we),
    .waddr_a (int_dst),
    .wdata_a (data32),
    .we_b    (1'b0),
    .waddr_b ('0),
    .wdata_b ('0),
    .raddr_0 (bus.Rs_ID),
    .raddr_1 (bus.Rt_ID),
    .rdata_0 (bus.Rs_data),
    .rdata_1 (bus.Rt_data)
  );

  regfile_2r2w #(.ZERO_R0(1'b0)) u_fp_rf (
    .Clk     (Clk),
    .Rst     (Rst),
    .we_a    (fp_we_lo),
    .waddr_a (fp_addr_lo),
    .wdata_a (fp_data_lo),
    .we_b    (fp_we_hi),
    .waddr_b (fp_addr_hi),
    .wdata_b (data64[63:32]),
    .raddr_0 (bus.Fs_ID),
    .raddr_1 (bus.Ft_ID),
    .rdata_0 (bus.Fs_data),
    .rdata_1 (bus.Ft_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      fcc_q      <= 1'b0;
      commit_cnt <= '0;
    end else begin
      case (hilo_sel)
        HILO_MULDIV: begin
          hi_q <= bus.OUT_ALU64_WB[63:32];
          lo_q <= bus.OUT_ALU64_WB[31:0];
        end
        HILO_HI: hi_q <= bus.HILO_write_WB;
        HILO_LO: lo_q <= bus.HILO_write_WB;
        default: ;
      endcase
      if (fcc_we) begin
        fcc_q <= bus.ALU_WB[0];
      end
      if (any_write) begin
        commit_cnt <= commit_cnt + 32'd1;
      end
    end
  end

  assign bus.HI_out       = hi_q;
  assign bus.LO_out       = lo_q;
  assign bus.FCC_out      = fcc_q;
  assign bus.Commit_count = commit_cnt;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: a behavioural architectural-state model
// checked every cycle, plus hand-computed literal expectations.
module tb_wb_commit_unit;

  logic Clk;
  logic Rst;
  wb_commit_unit_if bus();

  wb_commit_unit dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic [63:0] alu64;
    logic [63:0] data64;
    logic [31:0] mem32;
    logic [31:0] alu32;
    logic [4:0]  rd;
    logic [31:0] hilo_data;
    logic        reg_write;
    logic        mem2reg;
    logic        mem2reg64;
    logic        muldiv;
    logic        hilo_write;
    logic        jal;
    logic        fp_write;
    logic        load_byte;
    logic        float_write;
    logic        write64;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  fs;
    logic [4:0]  ft;
  } stim_t;

  int          assertCount = 0;
  int          failCount   = 0;
  bit          checkEn     = 1'b0;

  logic [31:0] mInt [32];
  logic [31:0] mFp  [32];
  logic [31:0] mHi;
  logic [31:0] mLo;
  logic        mFcc;
  logic [31:0] mCount;

  function automatic stim_t idleStim();
    stim_t s;
    s = '{rst: 1'b0, alu64: '0, data64: '0, mem32: '0, alu32: '0, rd: '0,
          hilo_data: '0, reg_write: 1'b0, mem2reg: 1'b0, mem2reg64: 1'b0,
          muldiv: 1'b0, hilo_write: 1'b0, jal: 1'b0, fp_write: 1'b0,
          load_byte: 1'b0, float_write: 1'b0, write64: 1'b0,
          rs: '0, rt: '0, fs: '0, ft: '0};
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge Clk);
    Rst                     = s.rst;
    bus.OUT_ALU64_WB        = s.alu64;
    bus.OUT_data64_WB       = s.data64;
    bus.Memory_WB           = s.mem32;
    bus.ALU_WB              = s.alu32;
    bus.RegWr_WB            = s.rd;
    bus.HILO_write_WB       = s.hilo_data;
    bus.RegWrite            = s.reg_write;
    bus.MemToReg            = s.mem2reg;
    bus.MemToReg64          = s.mem2reg64;
    bus.MulDiv_control      = s.muldiv;
    bus.HILO_write_control  = s.hilo_write;
    bus.Jal_control         = s.jal;
    bus.FPwrite_control     = s.fp_write;
    bus.Load_Byte_control   = s.load_byte;
    bus.float_control_write = s.float_write;
    bus.Write32_64          = s.write64;
    bus.Rs_ID               = s.rs;
    bus.Rt_ID               = s.rt;
    bus.Fs_ID               = s.fs;
    bus.Ft_ID               = s.ft;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Result word as the architecture defines it for the current WB fields.
  function automatic logic [31:0] modelData32();
    if (bus.Jal_control) return bus.ALU_WB;
    if (bus.MemToReg && bus.Load_Byte_control)
      return {{24{bus.Memory_WB[7]}}, bus.Memory_WB[7:0]};
    if (bus.MemToReg) return bus.Memory_WB;
    return bus.ALU_WB;
  endfunction

  function automatic logic [63:0] modelData64();
    return bus.MemToReg64 ? bus.OUT_data64_WB : bus.OUT_ALU64_WB;
  endfunction

  function automatic logic [31:0] expInt(input logic [4:0] idx);
    int dst;
    if (idx == 0) return 32'h0;
    if (!Rst && !bus.FPwrite_control && (bus.RegWrite || bus.Jal_control)) begin
      dst = bus.Jal_control ? 31 : int'(bus.RegWr_WB);
      if (dst == int'(idx)) return modelData32();
    end
    return mInt[idx];
  endfunction

  function automatic logic [31:0] expFp(input logic [4:0] idx);
    logic [63:0] d;
    if (!Rst && bus.FPwrite_control) begin
      if (bus.Write32_64 && (idx / 2) == (bus.RegWr_WB / 2)) begin
        d = modelData64();
        return (idx % 2 == 1) ? d[63:32] : d[31:0];
      end
      if (!bus.Write32_64 && idx == bus.RegWr_WB) return modelData32();
    end
    return mFp[idx];
  endfunction

  task automatic modelCommit();
    logic [63:0] d;
    bit          wrote;
    int          base;
    wrote = 1'b0;
    if (Rst) begin
      for (int i = 0; i < 32; i++) begin
        mInt[i] = '0;
        mFp[i]  = '0;
      end
      mHi = '0; mLo = '0; mFcc = 1'b0; mCount = '0;
      return;
    end
    if (bus.FPwrite_control) begin
      wrote = 1'b1;
      if (bus.Write32_64) begin
        d    = modelData64();
        base = (int'(bus.RegWr_WB) / 2) * 2;
        mFp[base]     = d[31:0];
        mFp[base + 1] = d[63:32];
      end else begin
        mFp[bus.RegWr_WB] = modelData32();
      end
    end else if (bus.RegWrite || bus.Jal_control) begin
      wrote = 1'b1;
      if (bus.Jal_control) mInt[31] = modelData32();
      else if (bus.RegWr_WB != 0) mInt[bus.RegWr_WB] = modelData32();
    end
    if (bus.MulDiv_control) begin
      wrote = 1'b1;
      mHi = bus.OUT_ALU64_WB[63:32];
      mLo = bus.OUT_ALU64_WB[31:0];
    end else if (bus.HILO_write_control) begin
      wrote = 1'b1;
      if (bus.RegWr_WB[0]) mHi = bus.HILO_write_WB;
      else mLo = bus.HILO_write_WB;
    end
    if (bus.float_control_write) begin
      wrote = 1'b1;
      mFcc  = bus.ALU_WB[0];
    end
    if (wrote) mCount = mCount + 32'd1;
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      modelCommit();
    end
  end

  // Compare process: every cycle, once inputs have settled after the negedge.
  initial begin
    forever begin
      @(negedge Clk);
      #2;
      if (checkEn) begin
        checkOutput("model_Rs", bus.Rs_data, expInt(bus.Rs_ID));
        checkOutput("model_Rt", bus.Rt_data, expInt(bus.Rt_ID));
        checkOutput("model_Fs", bus.Fs_data, expFp(bus.Fs_ID));
        checkOutput("model_Ft", bus.Ft_data, expFp(bus.Ft_ID));
        checkOutput("model_HI", bus.HI_out, mHi);
        checkOutput("model_LO", bus.LO_out, mLo);
        checkOutput("model_FCC", {31'd0, bus.FCC_out}, {31'd0, mFcc});
        checkOutput("model_count", bus.Commit_count, mCount);
      end
    end
  end

  initial begin
    stim_t s;

    // Reset with a write presented: it must be suppressed.
    s = idleStim();
    s.rst = 1'b1; s.reg_write = 1'b1; s.rd = 5'd5; s.alu32 = 32'h0000_0099; s.rs = 5'd5;
    Rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s = idleStim(); s.rs = 5'd5; s.rt = 5'd31; s.fs = 5'd5; s.ft = 5'd30;
    applyStimulus(s);
    checkEn = 1'b1;
    #3;
    checkOutput("reset_reg5", bus.Rs_data, 32'h0);
    checkOutput("reset_fp5", bus.Fs_data, 32'h0);
    checkOutput("reset_HI", bus.HI_out, 32'h0);
    checkOutput("reset_LO", bus.LO_out, 32'h0);
    checkOutput("reset_FCC", {31'd0, bus.FCC_out}, 32'h0);
    checkOutput("reset_count", bus.Commit_count, 32'h0);

    s = idleStim(); s.reg_write = 1'b1; s.rd = 5'd8; s.alu32 = 32'h1234_5678; s.rs = 5'd8;
    applyStimulus(s); #3;
    checkOutput("bypass_reg8", bus.Rs_data, 32'h1234_5678);
    s = idleStim(); s.rs = 5'd8; s.rt = 5'd8;
    applyStimulus(s); #3;
    checkOutput("stored_reg8", bus.Rt_data, 32'h1234_5678);

    s = idleStim(); s.reg_write = 1'b1; s.rd = 5'd0; s.alu32 = 32'hFFFF_0000; s.rs = 5'd0;
    applyStimulus(s); #3;
    checkOutput("bypass_reg0", bus.Rs_data, 32'h0);
    s = idleStim(); s.rs = 5'd0;
    applyStimulus(s); #3;
    checkOutput("stored_reg0", bus.Rs_data, 32'h0);

    s = idleStim(); s.reg_write = 1'b1; s.rd = 5'd5; s.alu32 = 32'h0000_0055;
    applyStimulus(s);

    s = idleStim(); s.reg_write = 1'b1; s.mem2reg = 1'b1; s.load_byte = 1'b1;
    s.mem32 = 32'h0000_0080; s.alu32 = 32'h1111_1111; s.rd = 5'd3;
    applyStimulus(s);
    s = idleStim(); s.reg_write = 1'b1; s.mem2reg = 1'b1; s.mem32 = 32'h8000_0080; s.rd = 5'd10;
    applyStimulus(s);
    s = idleStim(); s.jal = 1'b1; s.alu32 = 32'h0040_0008; s.rd = 5'd7; s.mem2reg = 1'b1;
    s.rs = 5'd3; s.rt = 5'd10;
    applyStimulus(s); #3;
    checkOutput("load_byte_reg3", bus.Rs_data, 32'hFFFF_FF80);
    checkOutput("load_word_reg10", bus.Rt_data, 32'h8000_0080);
    s = idleStim(); s.rs = 5'd31; s.rt = 5'd7;
    applyStimulus(s); #3;
    checkOutput("jal_reg31", bus.Rs_data, 32'h0040_0008);
    checkOutput("jal_reg7_untouched", bus.Rt_data, 32'h0);

    s = idleStim(); s.fp_write = 1'b1; s.write64 = 1'b1; s.mem2reg64 = 1'b1; s.reg_write = 1'b1;
    s.rd = 5'd5; s.data64 = 64'hAAAA_BBBB_CCCC_DDDD; s.alu64 = 64'h1111_2222_3333_4444;
    s.fs = 5'd4; s.ft = 5'd5; s.rs = 5'd5;
    applyStimulus(s); #3;
    checkOutput("bypass_fp4", bus.Fs_data, 32'hCCCC_DDDD);
    checkOutput("bypass_fp5", bus.Ft_data, 32'hAAAA_BBBB);
    s = idleStim(); s.fs = 5'd4; s.ft = 5'd5; s.rs = 5'd5;
    applyStimulus(s); #3;
    checkOutput("stored_fp4", bus.Fs_data, 32'hCCCC_DDDD);
    checkOutput("stored_fp5", bus.Ft_data, 32'hAAAA_BBBB);
    checkOutput("int_reg5_kept", bus.Rs_data, 32'h0000_0055);

    s = idleStim(); s.fp_write = 1'b1; s.rd = 5'd0; s.alu32 = 32'hDEAD_BEEF;
    applyStimulus(s);
    s = idleStim(); s.fs = 5'd0; s.ft = 5'd5;
    applyStimulus(s); #3;
    checkOutput("fp0_written", bus.Fs_data, 32'hDEAD_BEEF);

    s = idleStim(); s.muldiv = 1'b1; s.hilo_write = 1'b1; s.rd = 5'd1;
    s.alu64 = 64'h0000_0001_0000_0002; s.hilo_data = 32'h0000_0099;
    applyStimulus(s);
    s = idleStim(); s.hilo_write = 1'b1; s.rd = 5'd1; s.hilo_data = 32'h0000_0007;
    applyStimulus(s); #3;
    checkOutput("muldiv_HI", bus.HI_out, 32'h1);
    checkOutput("muldiv_LO", bus.LO_out, 32'h2);
    s = idleStim();
    applyStimulus(s); #3;
    checkOutput("mthi_HI", bus.HI_out, 32'h7);
    checkOutput("mthi_LO", bus.LO_out, 32'h2);

    force dut.commit_cnt = 32'hFFFF_FFFF;
    mCount = 32'hFFFF_FFFF;
    #1;
    release dut.commit_cnt;
    s = idleStim(); s.reg_write = 1'b1; s.rd = 5'd9; s.alu32 = 32'h1;
    applyStimulus(s);
    s = idleStim();
    applyStimulus(s); #3;
    checkOutput("count_wrap", bus.Commit_count, 32'h0);
    s = idleStim(); s.float_write = 1'b1; s.alu32 = 32'h0000_0001;
    applyStimulus(s); #3;
    checkOutput("count_idle", bus.Commit_count, 32'h0);
    s = idleStim();
    applyStimulus(s); #3;
    checkOutput("fcc_set", {31'd0, bus.FCC_out}, 32'h1);
    checkOutput("count_after_fcc", bus.Commit_count, 32'h1);

    applyStimulus(s);
    applyStimulus(s);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
